button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 16 +
 rtl/btn_debounce_ch.sv | 80 ++++++++
 rtl/button_conditioner.sv | 60 ++++++
 tb/tb_button_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared types and constants for the four-button conditioner.
package button_conditioner_pkg;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_e;

    localparam int unsigned DEFAULT_DEBOUNCE = 1000000;
    localparam int          CMD_ID_W         = 2;
    localparam int          NUM_BTN          = 4;

    function automatic logic [CMD_ID_W-1:0] lowest_idx(input logic [NUM_BTN-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (v[i]) lowest_idx = CMD_ID_W'(i);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- two-flop synchronizer, debounce FSM and counter,
// producing a registered debounced level and a one-cycle press strobe.
module btn_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int          CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d, pulse_q, pulse_d;
    logic             in_s;

    assign in_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!in_s)             state_d = IDLE;
                else if (cnt_q == LAST) state_d = PRESSED;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            PRESSED: begin
                if (!in_s) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (in_s)              state_d = PRESSED;
                else if (cnt_q == LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside the transition.
    always_comb begin
        level_d = (state_d == PRESSED) || (state_d == DEB_RELEASE);
        pulse_d = (state_q == DEB_PRESS) && (state_d == PRESSED);
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: four debounced push-buttons with a lowest-index-first command
// arbiter that serialises accepted presses for the LED-shift controller.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button0,
    input  logic                button1,
    input  logic                button2,
    input  logic                button3,
    output logic [NUM_BTN-1:0]  btn_level,
    output logic [NUM_BTN-1:0]  btn_pulse,
    output logic                cmd_valid,
    output logic [CMD_ID_W-1:0] cmd_id
);

    logic [NUM_BTN-1:0]  btn, pend_q, pend_d, pend_eff, grant;
    logic                cmd_valid_q, cmd_valid_d;
    logic [CMD_ID_W-1:0] cmd_id_q, cmd_id_d;

    assign btn = {button3, button2, button1, button0};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    // A fresh pulse on a bit that was already pending and is issued now re-arms that bit.
    always_comb begin
        pend_eff    = pend_q | btn_pulse;
        cmd_valid_d = |pend_eff;
        cmd_id_d    = lowest_idx(pend_eff);
        grant       = cmd_valid_d ? (NUM_BTN'(1) << cmd_id_d) : '0;
        pend_d      = (pend_eff & ~grant) | (btn_pulse & pend_q & grant);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
        end else begin
            pend_q      <= pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus randomized bouncing, checked every cycle
// against a run-length reference model of debouncing and a pending-set command model.
module tb_button_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] b;
    logic [3:0] btn_level, btn_pulse;
    logic       cmd_valid;
    logic [1:0] cmd_id;

    int n_tests = 0;
    int n_fail  = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .button0   (b[0]),
        .button1   (b[1]),
        .button2   (b[2]),
        .button3   (b[3]),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id)
    );

    always #5 clk = ~clk;

    // Reference model: synchronizer as a 2-deep delay; a level flips once the synchronized
    // input has disagreed with it for D+1 consecutive samples.
    logic [3:0] s1, s2, m_level, m_pulse, m_pend;
    logic       m_valid;
    logic [1:0] m_id;
    int         run [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        s1 = '0; s2 = '0; m_level = '0; m_pulse = '0; m_pend = '0;
        m_valid = 1'b0; m_id = '0;
        for (int i = 0; i < 4; i++) run[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] eff, old, samp;
        eff = m_pend | m_pulse;
        old = m_pend;
        m_valid = 1'b0;
        m_id = '0;
        for (int i = 3; i >= 0; i--)
            if (eff[i]) begin
                m_valid = 1'b1;
                m_id = 2'(i);
            end
        m_pend = eff;
        if (m_valid) m_pend[m_id] = old[m_id] & m_pulse[m_id];
        samp = s2; s2 = s1; s1 = b;
        m_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            if (samp[i] != m_level[i]) begin
                run[i]++;
                if (run[i] == D + 1) begin
                    m_level[i] = samp[i];
                    m_pulse[i] = samp[i];
                    run[i] = 0;
                end
            end else run[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_step(); else model_reset();
        @(negedge clk);
        chk("level", 32'(btn_level), 32'(m_level));
        chk("pulse", 32'(btn_pulse), 32'(m_pulse));
        chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
        chk("cmd_id", 32'(cmd_id), 32'(m_id));
    endtask

    task automatic idle(input int n);
        b = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_level"}, 32'(btn_level), 0);
        chk({tag, "_pulse"}, 32'(btn_pulse), 0);
        chk({tag, "_valid"}, 32'(cmd_valid), 0);
        chk({tag, "_id"}, 32'(cmd_id), 0);
    endtask

    initial begin
        int cnt, e0, e3, hold [4];
        rst = 1'b0;
        b = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        idle(3);

        // Single press on button1: pulse after edge 6, command after edge 7.
        b[1] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            if (e == 5) chk("p1_level_e5", 32'(btn_level[1]), 0);
            if (e == 6) begin
                chk("p1_pulse_e6", 32'(btn_pulse), 32'h2);
                chk("p1_level_e6", 32'(btn_level[1]), 1);
            end
            if (e == 7) begin
                chk("p1_valid_e7", 32'(cmd_valid), 1);
                chk("p1_id_e7", 32'(cmd_id), 1);
            end
        end
        idle(15);

        // Bouncing button2: first pulse after edge 10, exactly one command.
        cnt = 0;
        e0 = -1;
        for (int e = 0; e < 18; e++) begin
            b[2] = (e >= 4) || (e % 2 == 0);
            step();
            if (btn_pulse[2] && e0 < 0) e0 = e;
            if (cmd_valid && cmd_id == 2) cnt++;
        end
        chk("bounce_pulse_edge", 32'(e0), 10);
        chk("bounce_cmds", 32'(cnt), 1);
        idle(15);

        // Simultaneous button0 and button3 presses issue on consecutive cycles.
        e0 = -1;
        e3 = -1;
        b[0] = 1'b1;
        b[3] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            if (cmd_valid && cmd_id == 0) e0 = e;
            if (cmd_valid && cmd_id == 3) e3 = e;
        end
        chk("simul_id0_edge", 32'(e0), 7);
        chk("simul_id3_edge", 32'(e3), 8);
        idle(15);

        // Button3 press then release: level falls after edge r+6, no release command.
        b[3] = 1'b1;
        for (int e = 0; e < 12; e++) step();
        cnt = 0;
        b[3] = 1'b0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 5) chk("rel_level_r5", 32'(btn_level[3]), 1);
            if (e == 6) chk("rel_level_r6", 32'(btn_level[3]), 0);
            if (cmd_valid || btn_pulse != 0) cnt++;
        end
        chk("rel_no_cmd", 32'(cnt), 0);
        idle(10);

        // Reset mid-debounce while held: immediate clear, then one full debounce.
        b[0] = 1'b1;
        for (int e = 0; e < 4; e++) step();
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        step();
        step();
        rst = 1'b1;
        cnt = 0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (cmd_valid) cnt++;
        end
        chk("midrst_cmds", 32'(cnt), 1);
        idle(15);

        // Randomized bouncing with occasional resets.
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    b[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 20))
                                                          : int'($urandom_range(1, 4));
                end
                hold[i]--;
            end
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst = 1'b0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
